// File: rtl/id_ctrl_if.sv
// Handshake, instruction and control-bundle bus between IF/ID, the ID/EX
// control stage, EX and the external mul/div unit.
interface id_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [2:0]      alu_op;
  logic            alu1_src;
  logic            alu2_src;
  logic [1:0]      reg_dst;
  logic [2:0]      ext_sel;
  logic            sign;
  logic [1:0]      digit;
  logic            data_wr;
  logic            reg_wr;
  logic            imm_res;
  logic            branch;
  logic            jump;
  logic            md_op;
  logic            illegal;
  logic            md_start;
  logic [2:0]      md_funct;
  logic            md_done;
  logic            md_abort;

  modport master (
    output in_valid, instr, pc, flush, out_ready, md_done,
    input  in_ready, out_valid, out_pc, out_instr, alu_op, alu1_src, alu2_src,
           reg_dst, ext_sel, sign, digit, data_wr, reg_wr, imm_res, branch,
           jump, md_op, illegal, md_start, md_funct, md_abort
  );

  modport slave (
    input  in_valid, instr, pc, flush, out_ready, md_done,
    output in_ready, out_valid, out_pc, out_instr, alu_op, alu1_src, alu2_src,
           reg_dst, ext_sel, sign, digit, data_wr, reg_wr, imm_res, branch,
           jump, md_op, illegal, md_start, md_funct, md_abort
  );
endinterface

// File: rtl/id_ctrl_stage.sv
// Registered RV32I(+M) control decoder: decodes one instruction per cycle into
// an ID/EX bundle register with valid/ready flow, mul/div sequencing and flush.
module id_ctrl_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic clk,
  input logic rst,
  id_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, FULL = 2'b01, MD_WAIT = 2'b10} state_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu1_src;
    logic       alu2_src;
    logic [1:0] reg_dst;
    logic [2:0] ext_sel;
    logic       sign;
    logic [1:0] digit;
    logic       data_wr;
    logic       reg_wr;
    logic       imm_res;
    logic       branch;
    logic       jump;
    logic       md_op;
    logic       illegal;
  } ctrl_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  localparam ctrl_t CTRL_RESET = '{alu_op: 3'b000, alu1_src: 1'b0, alu2_src: 1'b0,
                                   reg_dst: 2'b00, ext_sel: 3'b000, sign: 1'b1,
                                   digit: 2'b00, data_wr: 1'b0, reg_wr: 1'b0,
                                   imm_res: 1'b0, branch: 1'b0, jump: 1'b0,
                                   md_op: 1'b0, illegal: 1'b0};

  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t      c;
    logic       bad;
    logic       writes;
    logic [6:0] f7;
    logic [2:0] f3;
    c      = CTRL_RESET;
    bad    = 1'b0;
    writes = 1'b0;
    f7     = ins[31:25];
    f3     = ins[14:12];
    case (ins[6:0])
      7'b0110011: begin
        writes = 1'b1;
        if (f7 == 7'b0000001) begin
          if (ENABLE_M) c.md_op = 1'b1;
          else          bad     = 1'b1;
        end else if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  c.alu_op = ALU_ADD;
            3'b001:  c.alu_op = ALU_SLL;
            3'b010:  begin c.alu_op = ALU_SUB; c.reg_dst = 2'b11; end
            3'b011:  begin c.alu_op = ALU_SUB; c.reg_dst = 2'b11; c.sign = 1'b0; end
            3'b100:  c.alu_op = ALU_XOR;
            3'b101:  c.alu_op = ALU_SRL;
            3'b110:  c.alu_op = ALU_OR;
            3'b111:  c.alu_op = ALU_AND;
            default: bad = 1'b1;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  c.alu_op = ALU_SUB;
            3'b101:  c.alu_op = ALU_SRA;
            default: bad = 1'b1;
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      7'b0010011: begin
        writes     = 1'b1;
        c.alu2_src = 1'b1;
        case (f3)
          3'b000:  c.alu_op = ALU_ADD;
          3'b010:  begin c.alu_op = ALU_SUB; c.reg_dst = 2'b11; end
          3'b011:  begin c.alu_op = ALU_SUB; c.reg_dst = 2'b11; c.sign = 1'b0; end
          3'b100:  c.alu_op = ALU_XOR;
          3'b110:  c.alu_op = ALU_OR;
          3'b111:  c.alu_op = ALU_AND;
          3'b001:  begin c.alu_op = ALU_SLL; c.ext_sel = 3'b001; bad = (f7 != 7'b0000000); end
          3'b101: begin
            c.ext_sel = 3'b001;
            if (f7 == 7'b0000000)      c.alu_op = ALU_SRL;
            else if (f7 == 7'b0100000) c.alu_op = ALU_SRA;
            else                       bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      7'b0000011: begin
        writes     = 1'b1;
        c.alu2_src = 1'b1;
        c.reg_dst  = 2'b01;
        case (f3)
          3'b000:  c.digit = 2'b10;
          3'b001:  c.digit = 2'b01;
          3'b010:  c.digit = 2'b00;
          3'b100:  begin c.digit = 2'b10; c.sign = 1'b0; end
          3'b101:  begin c.digit = 2'b01; c.sign = 1'b0; end
          default: bad = 1'b1;
        endcase
      end
      7'b0100011: begin
        c.data_wr  = 1'b1;
        c.alu2_src = 1'b1;
        c.ext_sel  = 3'b010;
        case (f3)
          3'b000:  c.digit = 2'b10;
          3'b001:  c.digit = 2'b01;
          3'b010:  c.digit = 2'b00;
          default: bad = 1'b1;
        endcase
      end
      7'b1100011: begin
        c.branch   = 1'b1;
        c.alu1_src = 1'b1;
        c.alu2_src = 1'b1;
        c.ext_sel  = 3'b011;
        case (f3)
          3'b000, 3'b001, 3'b100, 3'b101: c.sign = 1'b1;
          3'b110, 3'b111:                 c.sign = 1'b0;
          default:                        bad = 1'b1;
        endcase
      end
      7'b1101111: begin
        writes = 1'b1; c.jump = 1'b1; c.reg_dst = 2'b10;
        c.alu1_src = 1'b1; c.alu2_src = 1'b1; c.ext_sel = 3'b101;
      end
      7'b1100111: begin
        writes = 1'b1; c.jump = 1'b1; c.reg_dst = 2'b10;
        c.alu1_src = 1'b0; c.alu2_src = 1'b1; c.ext_sel = 3'b000;
        bad = (f3 != 3'b000);
      end
      7'b0110111: begin writes = 1'b1; c.imm_res = 1'b1; c.ext_sel = 3'b100; end
      7'b0010111: begin
        writes = 1'b1; c.alu1_src = 1'b1; c.alu2_src = 1'b1; c.ext_sel = 3'b100;
      end
      default: bad = 1'b1;
    endcase
    // An illegal bundle carries no side effects at all.
    if (bad) begin
      c         = CTRL_RESET;
      c.illegal = 1'b1;
    end else begin
      c.reg_wr = writes && (ins[11:7] != 5'd0);
    end
    return c;
  endfunction

  state_t          state_r;
  ctrl_t           ctrl_r;
  ctrl_t           dec_s;
  logic            out_valid_r;
  logic            md_start_r;
  logic            md_abort_r;
  logic [2:0]      md_funct_r;
  logic [XLEN-1:0] out_pc_r;
  logic [31:0]     out_instr_r;
  logic            in_ready_s;
  logic            take_s;

  assign dec_s      = decode(bus.instr);
  assign in_ready_s = !rst && !bus.flush &&
                      ((state_r == IDLE) || ((state_r == FULL) && bus.out_ready));
  assign take_s     = bus.in_valid && in_ready_s;

  // Stage FSM, bundle register and mul/div pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ctrl_r      <= CTRL_RESET;
      out_valid_r <= 1'b0;
      md_start_r  <= 1'b0;
      md_abort_r  <= 1'b0;
      md_funct_r  <= 3'b000;
      out_pc_r    <= '0;
      out_instr_r <= 32'd0;
    end else begin
      md_start_r <= 1'b0;
      md_abort_r <= 1'b0;
      if (bus.flush) begin
        state_r     <= IDLE;
        out_valid_r <= 1'b0;
        md_abort_r  <= (state_r == MD_WAIT);
      end else begin
        case (state_r)
          IDLE, FULL: begin
            if (take_s) begin
              ctrl_r      <= dec_s;
              out_pc_r    <= bus.pc;
              out_instr_r <= bus.instr;
              if (dec_s.md_op) begin
                state_r     <= MD_WAIT;
                out_valid_r <= 1'b0;
                md_start_r  <= 1'b1;
                md_funct_r  <= bus.instr[14:12];
              end else begin
                state_r     <= FULL;
                out_valid_r <= 1'b1;
              end
            end else if ((state_r == FULL) && bus.out_ready) begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
            end else begin
              state_r <= state_r;
            end
          end
          MD_WAIT: begin
            if (bus.md_done) begin
              state_r     <= FULL;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= MD_WAIT;
            end
          end
          default: begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_pc    = out_pc_r;
  assign bus.out_instr = out_instr_r;
  assign bus.alu_op    = ctrl_r.alu_op;
  assign bus.alu1_src  = ctrl_r.alu1_src;
  assign bus.alu2_src  = ctrl_r.alu2_src;
  assign bus.reg_dst   = ctrl_r.reg_dst;
  assign bus.ext_sel   = ctrl_r.ext_sel;
  assign bus.sign      = ctrl_r.sign;
  assign bus.digit     = ctrl_r.digit;
  assign bus.data_wr   = ctrl_r.data_wr;
  assign bus.reg_wr    = ctrl_r.reg_wr;
  assign bus.imm_res   = ctrl_r.imm_res;
  assign bus.branch    = ctrl_r.branch;
  assign bus.jump      = ctrl_r.jump;
  assign bus.md_op     = ctrl_r.md_op;
  assign bus.illegal   = ctrl_r.illegal;
  assign bus.md_start  = md_start_r;
  assign bus.md_funct  = md_funct_r;
  assign bus.md_abort  = md_abort_r;
endmodule
